mem_arbiter: RTL and testbench

//  Shares one memory port between the cpu instruction port (imem) and data port (dmem).

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the imem/dmem memory-port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_type;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_type;

  typedef struct packed {
    logic        valid;
    mem_req_type req;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
  } mem_out_type;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between imem and dmem; dmem has priority, bounded
// by a burst counter so a pending imem request is granted after MAX_DBURST dmem grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DBURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_valid,
  input  logic        imem_instr,
  input  logic [31:0] imem_addr,
  input  logic [31:0] imem_wdata,
  input  logic [3:0]  imem_wstrb,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic        dmem_instr,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [3:0] DLIM = 4'(MAX_DBURST);

  arb_state_type state, state_nxt;
  logic [3:0]    dcnt, dcnt_nxt;
  logic          grant;
  logic          grant_d;
  mem_req_type   sel;

  always_comb begin
    state_nxt  = state;
    dcnt_nxt   = dcnt;
    grant      = 1'b0;
    sel        = '0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    grant_d    = dmem_valid & ~(imem_valid & (dcnt == DLIM));

    case (state)
      IDLE: begin
        if (grant_d) begin
          grant     = 1'b1;
          state_nxt = BUSY_D;
          sel       = '{instr: dmem_instr, addr: dmem_addr, wdata: dmem_wdata, wstrb: dmem_wstrb};
          dcnt_nxt  = imem_valid ? sat_inc(dcnt, DLIM) : '0;
        end else if (imem_valid) begin
          grant     = 1'b1;
          state_nxt = BUSY_I;
          sel       = '{instr: imem_instr, addr: imem_addr, wdata: imem_wdata, wstrb: imem_wstrb};
          dcnt_nxt  = '0;
        end
      end
      BUSY_I: begin
        imem_ready = mem_ready;
        imem_rdata = mem_rdata;
        if (mem_ready) state_nxt = IDLE;
      end
      BUSY_D: begin
        dmem_ready = mem_ready;
        dmem_rdata = mem_rdata;
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_valid tracks "busy next cycle", which also forces the IDLE bubble after each completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dcnt      <= '0;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state     <= state_nxt;
      dcnt      <= dcnt_nxt;
      mem_valid <= (state_nxt != IDLE);
      if (grant) begin
        mem_instr <= sel.instr;
        mem_addr  <= sel.addr;
        mem_wdata <= sel.wdata;
        mem_wstrb <= sel.wstrb;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level owner/streak model, per-cycle compare, directed scenarios.
module tb_mem_arbiter;

  localparam int MAXD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_valid = 0, imem_instr = 0, dmem_valid = 0, dmem_instr = 0;
  logic [31:0] imem_addr = '0, imem_wdata = '0, dmem_addr = '0, dmem_wdata = '0;
  logic [3:0]  imem_wstrb = '0, dmem_wstrb = '0;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic        imem_ready, dmem_ready, mem_valid, mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DBURST(MAXD)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_s(input string name, input string act, input string exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    failed++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Memory responder: answers wait_cycles cycles after seeing mem_valid, unless manual.
  int wait_cycles = 0;
  bit manual = 0;
  int rcnt = 0;
  always @(posedge clk) begin
    #1;
    mem_rdata = $urandom;
    if (!manual) begin
      if (!rst || !mem_valid || mem_ready) begin
        mem_ready = 1'b0;
        rcnt = 0;
      end else if (rcnt >= wait_cycles) mem_ready = 1'b1;
      else rcnt++;
    end
  end

  // Model: who owns the memory (0 none, 1 imem, 2 dmem) and how many dmem grants in a row imem waited.
  int          owner = 0;
  int          streak = 0;
  logic        m_instr = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  string       model_log = "";

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner = 0; streak = 0;
      m_instr = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    end else if (owner != 0) begin
      if (mem_ready) owner = 0;
    end else if (dmem_valid && !(imem_valid && streak >= MAXD)) begin
      owner = 2;
      m_instr = dmem_instr; m_addr = dmem_addr; m_wdata = dmem_wdata; m_wstrb = dmem_wstrb;
      streak = imem_valid ? ((streak + 1 > MAXD) ? MAXD : streak + 1) : 0;
      model_log = {model_log, "D"};
    end else if (imem_valid) begin
      owner = 1;
      m_instr = imem_instr; m_addr = imem_addr; m_wdata = imem_wdata; m_wstrb = imem_wstrb;
      streak = 0;
      model_log = {model_log, "I"};
    end
  end

  always @(negedge clk) begin
    check("mem_valid", {31'd0, mem_valid}, {31'd0, owner != 0});
    check("mem_instr", {31'd0, mem_instr}, {31'd0, m_instr});
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, m_wstrb});
    check("imem_ready", {31'd0, imem_ready}, {31'd0, owner == 1 && mem_ready});
    check("dmem_ready", {31'd0, dmem_ready}, {31'd0, owner == 2 && mem_ready});
    check("imem_rdata", imem_rdata, (owner == 1) ? mem_rdata : 32'd0);
    check("dmem_rdata", dmem_rdata, (owner == 2) ? mem_rdata : 32'd0);
  end

  // Observed grant order and ready-pulse counts from the DUT side.
  string dut_log = "";
  int    ipulse = 0, dpulse = 0;
  logic  prev_valid = 0;
  always @(negedge clk) begin
    if (mem_valid && !prev_valid) dut_log = {dut_log, mem_instr ? "I" : "D"};
    prev_valid = mem_valid;
    if (imem_ready) ipulse++;
    if (dmem_ready) dpulse++;
  end

  task automatic clear_logs();
    dut_log = ""; model_log = ""; ipulse = 0; dpulse = 0;
  endtask

  task automatic wait_ready(input bit is_d, input string name);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = is_d ? dmem_ready : imem_ready;
    end
    if (!seen) timeout(name);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst imem_ready", {31'd0, imem_ready}, 32'd0);
    @(posedge clk); #1 rst = 1;

    // 1: imem fetch alone, memory answers after 2 waits
    wait_cycles = 2;
    clear_logs();
    imem_valid = 1; imem_instr = 1; imem_addr = 32'h100;
    @(posedge clk); #1;
    check("t1 valid N+1", {31'd0, mem_valid}, 32'd1);
    check("t1 addr", mem_addr, 32'h100);
    check("t1 instr", {31'd0, mem_instr}, 32'd1);
    wait_ready(0, "t1 imem_ready");
    check("t1 rdata", imem_rdata, mem_rdata);
    @(posedge clk); #1 imem_valid = 0;
    repeat (3) @(posedge clk);
    check("t1 ipulse", ipulse, 32'd1);
    check("t1 dpulse", dpulse, 32'd0);

    // 2: simultaneous requests, dmem first then imem after the bubble
    wait_cycles = 1;
    clear_logs();
    #1;
    dmem_valid = 1; dmem_instr = 0; dmem_addr = 32'h2000;
    imem_valid = 1; imem_addr = 32'h104;
    @(posedge clk); #1;
    check("t2 first addr", mem_addr, 32'h2000);
    wait_ready(1, "t2 dmem_ready");
    @(posedge clk); #1 dmem_valid = 0;
    wait_ready(0, "t2 imem_ready");
    @(posedge clk); #1 imem_valid = 0;
    repeat (3) @(posedge clk);
    check_s("t2 dut order", dut_log, "DI");
    check_s("t2 model order", model_log, "DI");

    // 3: sustained contention, burst limit forces imem in every fifth grant
    wait_cycles = 0;
    clear_logs();
    #1;
    dmem_valid = 1; imem_valid = 1;
    begin
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
        @(negedge clk); #1;
        done = (dut_log.len() >= 10);
      end
      if (!done) timeout("t3 ten grants");
    end
    @(posedge clk); #1 dmem_valid = 0; imem_valid = 0;
    repeat (3) @(posedge clk);
    check_s("t3 dut order", dut_log, "DDDDIDDDDI");
    check_s("t3 model order", model_log, "DDDDIDDDDI");

    // 4: dmem write with 5 wait cycles, fields must hold
    wait_cycles = 5;
    clear_logs();
    #1;
    dmem_valid = 1; dmem_addr = 32'h3000; dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'b0011;
    begin
      int  hold = 0;
      bit  seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clk);
        if (mem_valid) begin
          hold++;
          check("t4 wdata", mem_wdata, 32'hDEADBEEF);
          check("t4 wstrb", {28'd0, mem_wstrb}, 32'h3);
          check("t4 addr", mem_addr, 32'h3000);
        end
        seen = dmem_ready;
      end
      if (!seen) timeout("t4 dmem_ready");
      check("t4 hold cycles", hold, 32'd6);
    end
    @(posedge clk); #1 dmem_valid = 0; dmem_wstrb = '0;
    repeat (3) @(posedge clk);
    check("t4 dpulse", dpulse, 32'd1);
    check("t4 ipulse", ipulse, 32'd0);

    // 5: async reset in BUSY_I aborts without a later ready
    wait_cycles = 20;
    clear_logs();
    #1;
    imem_valid = 1; imem_addr = 32'h400;
    begin
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        seen = mem_valid;
      end
      if (!seen) timeout("t5 mem_valid");
    end
    @(negedge clk); #2 rst = 0;
    #1;
    check("t5 async valid", {31'd0, mem_valid}, 32'd0);
    check("t5 async addr", mem_addr, 32'd0);
    imem_valid = 0;
    @(posedge clk); @(posedge clk); #1 rst = 1;
    repeat (25) @(posedge clk);
    check("t5 no stale ready", ipulse, 32'd0);

    // 6: stray mem_ready in IDLE, then a normal request still gets N+1 latency
    manual = 1;
    @(posedge clk); #2 mem_ready = 1;
    repeat (2) begin
      @(negedge clk);
      check("t6 imem_ready", {31'd0, imem_ready}, 32'd0);
      check("t6 dmem_ready", {31'd0, dmem_ready}, 32'd0);
      check("t6 mem_valid", {31'd0, mem_valid}, 32'd0);
    end
    @(posedge clk); #2 mem_ready = 0; manual = 0;
    wait_cycles = 0;
    clear_logs();
    dmem_valid = 1; dmem_addr = 32'h5004;
    @(posedge clk); #1;
    check("t6 valid N+1", {31'd0, mem_valid}, 32'd1);
    check("t6 addr", mem_addr, 32'h5004);
    wait_ready(1, "t6 dmem_ready");
    @(posedge clk); #1 dmem_valid = 0;
    repeat (3) @(posedge clk);
    check("t6 dpulse", dpulse, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
